// File: rtl/layer_composer.sv
// layer_composer: scales and mixes two palette-indexed layers into one output line.
//
// A line starts on line_start. Each accepted next_pixel request advances a
// 10.7 fixed-point position accumulator by hscale and drives its integer part
// onto composer_rd_idx. Both line buffers answer one cycle later; the mix
// (layer1 over layer0 over bg_color, 8'h00 = transparent) is registered on the
// following edge. pixel_valid therefore rises two clocks after each accepted
// request, one output per request, in order.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   line_start                       one-cycle pulse, (re)starts a line
//   next_pixel                       per-cycle pixel request
//   hscale[7:0]                      horizontal step, 1.7 fixed point
//   layer0_en, layer1_en             layer enables
//   bg_color[7:0]                    index used when no layer pixel is opaque
//   composer_rd_idx[9:0]             read index to both line buffers
//   layer0_rd_data, layer1_rd_data   line buffer data, one cycle after the index
//   pixel_data[7:0], pixel_valid     composed output and its qualifier
//   line_done                        pulses with the last pixel of a full line
module layer_composer #(
  parameter int LINE_PIXELS = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       next_pixel,
  input  logic [7:0] hscale,
  input  logic       layer0_en,
  input  logic       layer1_en,
  input  logic [7:0] bg_color,
  output logic [9:0] composer_rd_idx,
  input  logic [7:0] layer0_rd_data,
  input  logic [7:0] layer1_rd_data,
  output logic [7:0] pixel_data,
  output logic       pixel_valid,
  output logic       line_done
);

  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam int STAGES = 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(LINE_PIXELS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [16:0]       acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [9:0]        rd_idx_q, rd_idx_d;
  logic [7:0]        pixel_data_q, pixel_data_d;
  // [0] aligned with composer_rd_idx, [1] with the line buffer data,
  // [STAGES] with the registered output.
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]   last_pipe_q, last_pipe_d;

  logic accept;
  logic last_req;
  logic [7:0] mix;

  always_comb begin
    if (layer1_en && (layer1_rd_data != 8'h00))      mix = layer1_rd_data;
    else if (layer0_en && (layer0_rd_data != 8'h00)) mix = layer0_rd_data;
    else                                             mix = bg_color;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rd_idx_d     = rd_idx_q;
    pixel_data_d = pixel_data_q;

    // line_start wins over a same-cycle request.
    accept   = (state_q == ACTIVE) && next_pixel && !line_start;
    last_req = (cnt_q == LAST_CNT);

    vld_pipe_d  = {vld_pipe_q[STAGES-1:0], accept};
    last_pipe_d = {last_pipe_q[STAGES-1:0], accept && last_req};

    if (line_start) begin
      state_d     = ACTIVE;
      acc_d       = '0;
      cnt_d       = '0;
      // Drop everything in flight, including the pixel that would have
      // emerged on this very edge.
      vld_pipe_d  = '0;
      last_pipe_d = '0;
    end else if (accept) begin
      rd_idx_d = acc_q[16:7];
      acc_d    = acc_q + 17'(hscale);  // wraps modulo 2^17 by width
      cnt_d    = cnt_q + 1'b1;
      if (last_req) state_d = IDLE;
    end

    // Output holds its last value between valid pixels.
    if (vld_pipe_d[STAGES]) pixel_data_d = mix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      pixel_data_q <= '0;
      vld_pipe_q   <= '0;
      last_pipe_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rd_idx_q     <= rd_idx_d;
      pixel_data_q <= pixel_data_d;
      vld_pipe_q   <= vld_pipe_d;
      last_pipe_q  <= last_pipe_d;
    end
  end

  assign composer_rd_idx = rd_idx_q;
  assign pixel_data      = pixel_data_q;
  assign pixel_valid     = vld_pipe_q[STAGES];
  assign line_done       = last_pipe_q[STAGES];

endmodule

// File: tb/tb_layer_composer.sv
// Directed bench for layer_composer: reset, unity/half/zero/wrap scaling,
// layer priority, mid-line restart and mid-line reset. Line buffers are
// modelled as synchronous-read memories (data one clock after the index).
module tb_layer_composer;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_start;
  logic       next_pixel;
  logic [7:0] hscale;
  logic       layer0_en, layer1_en;
  logic [7:0] bg_color;
  logic [9:0] composer_rd_idx;
  logic [7:0] layer0_rd_data, layer1_rd_data;
  logic [7:0] pixel_data;
  logic       pixel_valid;
  logic       line_done;

  logic [7:0] l0_mem [1024];
  logic [7:0] l1_mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_composer #(.LINE_PIXELS(640)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_pixel(next_pixel),
    .hscale(hscale), .layer0_en(layer0_en), .layer1_en(layer1_en),
    .bg_color(bg_color), .composer_rd_idx(composer_rd_idx),
    .layer0_rd_data(layer0_rd_data), .layer1_rd_data(layer1_rd_data),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .line_done(line_done)
  );

  always @(posedge clk) begin
    layer0_rd_data <= l0_mem[composer_rd_idx];
    layer1_rd_data <= l1_mem[composer_rd_idx];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_line;
    line_start = 1'b1;
    next_pixel = 1'b0;
    tick();
    line_start = 1'b0;
  endtask

  task automatic fill_pattern;
    for (int i = 0; i < 1024; i++) begin
      l0_mem[i] = 8'(i);
      l1_mem[i] = (i % 5 == 0) ? (8'hC0 | 8'(i % 16)) : 8'h00;
    end
    layer0_en = 1'b1;
    layer1_en = 1'b1;
    bg_color  = 8'h0F;
  endtask

  // Expected composed pixel for buffer index j with the pattern above,
  // both layers enabled, bg 8'h0F.
  function automatic logic [7:0] exp_pix(input int j);
    logic [7:0] a, b;
    b = (j % 5 == 0) ? (8'hC0 | 8'(j % 16)) : 8'h00;
    a = 8'(j);
    if (b != 8'h00) return b;
    if (a != 8'h00) return a;
    return 8'h0F;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({composer_rd_idx, pixel_data, pixel_valid, line_done} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: idx=%0d data=%h valid=%b done=%b, required all 0",
               composer_rd_idx, pixel_data, pixel_valid, line_done);
    end
    rst = 1'b0;
    // next_pixel in IDLE is ignored
    next_pixel = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (composer_rd_idx !== 10'd0 || pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: idx=%0d valid=%b, required idx 0 valid 0",
               composer_rd_idx, pixel_valid);
    end
    next_pixel = 1'b0;
  endtask

  task automatic test_unity;
    int bad_idx = 0, bad_v = 0, bad_d = 0, bad_ld = 0;
    logic exp_v;
    fill_pattern();
    hscale = 8'd128;
    start_line();
    for (int c = 0; c < 644; c++) begin
      next_pixel = (c < 640);
      tick();
      if (c < 640 && composer_rd_idx !== 10'(c)) bad_idx++;
      exp_v = (c >= 2 && c < 642);
      if (pixel_valid !== exp_v) bad_v++;
      if (exp_v && pixel_data !== exp_pix(c - 2)) bad_d++;
      if (line_done !== (c == 641)) bad_ld++;
    end
    checks++;
    if (bad_idx != 0) begin errors++; $display("FAIL unity_idx: %0d bad indices, required 0", bad_idx); end
    checks++;
    if (bad_v != 0) begin errors++; $display("FAIL unity_valid: %0d bad valid cycles, required 0", bad_v); end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL unity_data: %0d bad pixels, required 0", bad_d); end
    checks++;
    if (bad_ld != 0) begin errors++; $display("FAIL unity_line_done: %0d bad cycles, required 0", bad_ld); end
    // Line finished: back in IDLE, further requests ignored
    next_pixel = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (composer_rd_idx !== 10'd639 || pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL unity_idle_after: idx=%0d valid=%b, required idx 639 valid 0",
               composer_rd_idx, pixel_valid);
    end
    next_pixel = 1'b0;
  endtask

  task automatic test_half;
    logic [9:0] exp_h [6];
    exp_h = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd2, 10'd2};
    hscale = 8'd64;
    start_line();
    for (int k = 0; k < 6; k++) begin
      next_pixel = 1'b1;
      tick();
      checks++;
      if (composer_rd_idx !== exp_h[k]) begin
        errors++;
        $display("FAIL half_idx[%0d]: got %0d, required %0d", k, composer_rd_idx, exp_h[k]);
      end
      if (k == 2) begin
        next_pixel = 1'b0;  // gap: index must hold
        tick();
        checks++;
        if (composer_rd_idx !== 10'd1) begin
          errors++;
          $display("FAIL half_gap_hold: got %0d, required 1", composer_rd_idx);
        end
      end
    end
    next_pixel = 1'b0;
  endtask

  task automatic test_zero_scale;
    int bad_idx = 0, ld_at = -1, ld_cnt = 0;
    hscale = 8'd0;
    start_line();
    for (int c = 0; c < 644; c++) begin
      next_pixel = (c < 640);
      tick();
      if (composer_rd_idx !== 10'd0) bad_idx++;
      if (line_done === 1'b1) begin ld_cnt++; ld_at = c; end
    end
    checks++;
    if (bad_idx != 0) begin errors++; $display("FAIL zero_idx: %0d nonzero indices, required 0", bad_idx); end
    checks++;
    if (ld_cnt != 1 || ld_at != 641) begin
      errors++;
      $display("FAIL zero_line_done: count=%0d at=%0d, required count 1 at 641", ld_cnt, ld_at);
    end
    next_pixel = 1'b0;
  endtask

  task automatic test_wrap;
    logic [9:0] exp_w [5];
    int bad_v = 0;
    exp_w = '{10'd0, 10'd1, 10'd3, 10'd5, 10'd7};
    hscale = 8'd255;
    start_line();
    for (int k = 0; k < 520; k++) begin
      next_pixel = 1'b1;
      tick();
      if (k < 5) begin
        checks++;
        if (composer_rd_idx !== exp_w[k]) begin
          errors++;
          $display("FAIL wrap_idx[%0d]: got %0d, required %0d", k, composer_rd_idx, exp_w[k]);
        end
      end
      if (k == 514) begin
        checks++;
        if (composer_rd_idx !== 10'd1023) begin
          errors++;
          $display("FAIL wrap_top: got %0d, required 1023", composer_rd_idx);
        end
      end
      if (k == 515) begin
        checks++;
        if (composer_rd_idx !== 10'd1) begin
          errors++;
          $display("FAIL wrap_past: got %0d, required 1", composer_rd_idx);
        end
      end
      if (pixel_valid !== (k >= 2)) bad_v++;
    end
    checks++;
    if (bad_v != 0) begin errors++; $display("FAIL wrap_no_stall: %0d bad valid cycles, required 0", bad_v); end
    next_pixel = 1'b0;
  endtask

  task automatic test_priority;
    logic [7:0] t_l1 [5], t_l0 [5], t_exp [5];
    logic       t_en1 [5];
    t_l1  = '{8'h00, 8'h12, 8'h12, 8'h12, 8'h00};
    t_l0  = '{8'h35, 8'h35, 8'h35, 8'h00, 8'h00};
    t_en1 = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    t_exp = '{8'h35, 8'h12, 8'h35, 8'h0F, 8'h0F};
    hscale    = 8'd128;
    bg_color  = 8'h0F;
    layer0_en = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 1024; i++) begin
        l0_mem[i] = t_l0[t];
        l1_mem[i] = t_l1[t];
      end
      layer1_en = t_en1[t];
      start_line();
      next_pixel = 1'b1;
      tick();
      next_pixel = 1'b0;
      tick();
      tick();
      checks++;
      if (pixel_valid !== 1'b1 || pixel_data !== t_exp[t]) begin
        errors++;
        $display("FAIL priority[%0d]: valid=%b data=%h, required valid 1 data %h",
                 t, pixel_valid, pixel_data, t_exp[t]);
      end
      tick();
      checks++;
      if (pixel_valid !== 1'b0 || pixel_data !== t_exp[t]) begin
        errors++;
        $display("FAIL priority_hold[%0d]: valid=%b data=%h, required valid 0 data %h",
                 t, pixel_valid, pixel_data, t_exp[t]);
      end
    end
  endtask

  task automatic test_restart;
    fill_pattern();
    hscale = 8'd128;
    start_line();
    next_pixel = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    line_start = 1'b1;  // same cycle as request for pixel 100
    tick();
    line_start = 1'b0;
    checks++;
    if (composer_rd_idx !== 10'd99 || pixel_valid !== 1'b0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_edge: idx=%0d valid=%b done=%b, required idx 99 valid 0 done 0",
               composer_rd_idx, pixel_valid, line_done);
    end
    tick();
    checks++;
    if (composer_rd_idx !== 10'd0 || pixel_valid !== 1'b0 || line_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_first: idx=%0d valid=%b done=%b, required idx 0 valid 0 done 0",
               composer_rd_idx, pixel_valid, line_done);
    end
    tick();
    checks++;
    if (composer_rd_idx !== 10'd1 || pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_second: idx=%0d valid=%b, required idx 1 valid 0",
               composer_rd_idx, pixel_valid);
    end
    tick();
    checks++;
    if (pixel_valid !== 1'b1 || pixel_data !== exp_pix(0)) begin
      errors++;
      $display("FAIL restart_pixel0: valid=%b data=%h, required valid 1 data %h",
               pixel_valid, pixel_data, exp_pix(0));
    end
    next_pixel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    hscale = 8'd128;
    start_line();
    next_pixel = 1'b1;
    for (int k = 0; k < 50; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({composer_rd_idx, pixel_data, pixel_valid, line_done} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: idx=%0d data=%h valid=%b done=%b, required all 0",
               composer_rd_idx, pixel_data, pixel_valid, line_done);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pixel_valid !== 1'b0 || line_done !== 1'b0 || composer_rd_idx !== 10'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_idle: %0d bad cycles, required 0", bad); end
    start_line();
    next_pixel = 1'b1;
    tick();
    checks++;
    if (composer_rd_idx !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid_new_idx0: got %0d, required 0", composer_rd_idx);
    end
    tick();
    tick();
    checks++;
    if (composer_rd_idx !== 10'd2 || pixel_valid !== 1'b1 || pixel_data !== exp_pix(0)) begin
      errors++;
      $display("FAIL reset_mid_new_line: idx=%0d valid=%b data=%h, required idx 2 valid 1 data %h",
               composer_rd_idx, pixel_valid, pixel_data, exp_pix(0));
    end
    next_pixel = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    line_start = 1'b0;
    next_pixel = 1'b0;
    hscale     = 8'd128;
    fill_pattern();
    test_reset();
    test_unity();
    test_half();
    test_zero_scale();
    test_wrap();
    test_priority();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_composer.md
LAYER_COMPOSER -- requirements
Module: layer_composer

Interface
REQ-001 Parameter LINE_PIXELS, default 640: pixels emitted per active line.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on rising clk.
REQ-004 line_start  input  1  one-cycle pulse that starts a new line.
REQ-005 next_pixel  input  1  per-cycle pixel request from the video output stage.
REQ-006 hscale  input  8  horizontal step, unsigned 1.7 fixed point (128 = 1.0).
REQ-007 layer0_en, layer1_en  input  1 each  layer enables.
REQ-008 bg_color  input  8  palette index used when no layer pixel is opaque.
REQ-009 composer_rd_idx  output  10  read index driven to both layer line buffers.
REQ-010 layer0_rd_data, layer1_rd_data  input  8 each  line-buffer read data, valid one cycle after composer_rd_idx.
REQ-011 pixel_data  output  8  composed palette index.
REQ-012 pixel_valid  output  1  pixel_data qualifier.
REQ-013 line_done  output  1  one-cycle pulse coincident with the last pixel_valid of a line.

Function
REQ-014 Control is a two-state FSM, IDLE and ACTIVE.
REQ-015 Transitions:
- IDLE to ACTIVE on line_start.
- ACTIVE to ACTIVE on line_start, which restarts the line.
- ACTIVE to IDLE on the cycle the LINE_PIXELS-th request is accepted.
REQ-016 On line_start:
- 17-bit position accumulator (10 integer . 7 fraction) cleared to 0.
- Accepted-pixel counter cleared to 0.
- Pipeline valid bits cleared, so in-flight pixels are discarded.
REQ-017 A request is accepted only when state is ACTIVE, next_pixel=1 and line_start=0; line_start has priority in the same cycle.
REQ-018 On an accepted request, in one clock:
- composer_rd_idx <= accumulator[16:7].
- accumulator <= accumulator + hscale, modulo 2^17.
- Counter increments.
REQ-019 Index wrap: the accumulator and index wrap silently past 1023; no saturation and no error flag.
REQ-020 hscale=0: every pixel of the line reads index 0, and the counter still advances.
REQ-021 Without an accepted request, composer_rd_idx and the accumulator hold their values, and next_pixel in IDLE is ignored.
REQ-022 Read data is sampled exactly one cycle after composer_rd_idx updates, and the mix result is registered the cycle after that.
REQ-023 Total latency: pixel_valid=1 two cycles after each accepted request, one output per accepted request, order preserved.
REQ-024 Mix priority, where a pixel is transparent when its value is 8'h00:
- layer1_en and layer1 pixel nonzero: output layer1.
- else layer0_en and layer0 pixel nonzero: output layer0.
- else: output bg_color, sampled in the same cycle as the layer data.
REQ-025 pixel_data holds its last value while pixel_valid=0.
REQ-026 line_done=1 for exactly the cycle carrying the LINE_PIXELS-th pixel_valid of an uninterrupted line; no line_done for a line restarted by line_start.
REQ-027 Back-to-back next_pixel every cycle sustains one pixel per clock with no bubbles.

Reset
REQ-028 While rst=1, on each clock:
- state <= IDLE, accumulator <= 0, counter <= 0.
- composer_rd_idx <= 0, pixel_data <= 0.
- pixel_valid <= 0, line_done <= 0.
- Pipeline valid bits <= 0.
REQ-029 Reset asserted mid-line discards all in-flight pixels, and no pixel_valid or line_done is produced from them.
REQ-030 The first line_start accepted after reset deasserts behaves identically to one from power-up.

Verification
REQ-031 Scenario 1, unity scale: hscale=128, line_start, then next_pixel held high for 640 cycles. Required:
- composer_rd_idx = 0..639.
- 640 consecutive pixel_valid cycles starting 2 cycles after the first request.
- line_done on the last one, then IDLE.
REQ-032 Scenario 2, half scale: hscale=64, 6 requests -> composer_rd_idx sequence 0,0,1,1,2,2.
REQ-033 Scenario 3, priority: layer1=8'h00, layer0=8'h35, bg_color=8'h0F, both enabled -> pixel_data=8'h35. Then:
- layer1 becomes 8'h12 -> 8'h12.
- layer1_en=0 -> 8'h35.
- layer0 also 8'h00 -> 8'h0F.
REQ-034 Scenario 4, restart: line_start in the same cycle as next_pixel at pixel 100. Required:
- That request is not accepted, and the next accepted request reads index 0.
- The two in-flight pixels produce no pixel_valid, and no line_done is emitted.
REQ-035 Scenario 5, wrap: hscale=255, 5 requests -> composer_rd_idx sequence 0,1,3,5,7, and the index wraps to 0-based values past 1023 with no stall.
REQ-036 Scenario 6, reset: rst=1 during pixel 50 of a line -> next cycle all outputs 0 and state IDLE, with no further pixel_valid until a new line_start.
